// File: rtl/biquad_filter_engine.sv
// Sequential Direct Form I biquad with a serial b0 normalizer and a shadow coefficient bank.
// A single MAC is time-shared across the five taps; new coefficients commit only between samples.
module biquad_filter_engine #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned Q_WIDTH      = 24,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned ACC_WIDTH    = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  input  logic [DATA_WIDTH-1:0]   a0,
  input  logic [DATA_WIDTH-1:0]   a1,
  input  logic [DATA_WIDTH-1:0]   a2,
  input  logic [DATA_WIDTH-1:0]   b0,
  input  logic [DATA_WIDTH-1:0]   b1,
  input  logic [DATA_WIDTH-1:0]   b2,
  output logic                    coef_error,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_sample
);

  localparam int DivW    = DATA_WIDTH + Q_WIDTH;
  localparam int ProdW   = DATA_WIDTH + SAMPLE_WIDTH;
  localparam int CntW    = $clog2(DivW);
  localparam int NumCoef = 5;

  localparam logic [DATA_WIDTH-1:0] CoefMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] CoefMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] CoefOne =
      {{(DATA_WIDTH-Q_WIDTH-1){1'b0}}, 1'b1, {Q_WIDTH{1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] RoundHalf =
      {{(ACC_WIDTH-Q_WIDTH){1'b0}}, 1'b1, {(Q_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] SmpMax =
      {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SmpMin =
      {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [2:0] LastIdx = 3'd4;

  typedef enum logic [1:0] {CoefIdle, CoefDiv, CoefFin, CoefWait} coef_state_e;
  typedef enum logic [1:0] {SmpIdle, SmpMac, SmpRound, SmpOut} smp_state_e;

  coef_state_e coef_state_q, coef_state_d;
  smp_state_e  smp_state_q, smp_state_d;

  logic                  coef_error_q, coef_error_d;
  logic [DATA_WIDTH-1:0] num_q [NumCoef];
  logic [DATA_WIDTH-1:0] num_d [NumCoef];
  logic [DATA_WIDTH-1:0] shadow_q [NumCoef];
  logic [DATA_WIDTH-1:0] shadow_d [NumCoef];
  logic [DATA_WIDTH-1:0] act_q [NumCoef];
  logic [DATA_WIDTH-1:0] act_d [NumCoef];
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DivW-1:0]       quo_q, quo_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]            coef_idx_q, coef_idx_d;

  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] in_abs, next_abs, div_res;

  logic [2:0]                   mac_cnt_q, mac_cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0]      x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic [SAMPLE_WIDTH-1:0]      y1_q, y1_d, y2_q, y2_d;
  logic [SAMPLE_WIDTH-1:0]      out_sample_q, out_sample_d;

  logic signed [DATA_WIDTH-1:0]   mac_coef;
  logic signed [SAMPLE_WIDTH-1:0] mac_x;
  logic signed [ProdW-1:0]        coef_ext, x_ext, prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc_rnd, y_full;
  logic [SAMPLE_WIDTH-1:0]        y_sat;

  logic commit_pending;

  assign commit_pending = (coef_state_q == CoefWait);

  // Coefficient path: capture, serial restoring division, then wait for a sample boundary.
  always_comb begin
    coef_state_d = coef_state_q;
    coef_error_d = coef_error_q;
    num_d        = num_q;
    shadow_d     = shadow_q;
    act_d        = act_q;
    div_d        = div_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    bit_cnt_d    = bit_cnt_q;
    coef_idx_d   = coef_idx_q;

    trial    = {rem_q, quo_q[DivW-1]};
    in_abs   = a0[DATA_WIDTH-1] ? -a0 : a0;
    next_abs = num_q[1][DATA_WIDTH-1] ? -num_q[1] : num_q[1];

    // Divisor is always positive, so the quotient takes the numerator's sign.
    if (num_q[0][DATA_WIDTH-1]) begin
      if (quo_q > DivW'(CoefMin)) div_res = CoefMin;
      else                        div_res = -quo_q[DATA_WIDTH-1:0];
    end else begin
      if (quo_q > DivW'(CoefMax)) div_res = CoefMax;
      else                        div_res = quo_q[DATA_WIDTH-1:0];
    end

    unique case (coef_state_q)
      CoefIdle: begin
        if (coef_valid) begin
          if (b0[DATA_WIDTH-1] || (b0 == '0)) begin
            coef_error_d = 1'b1;
          end else begin
            coef_error_d = 1'b0;
            num_d[0]     = a0;
            num_d[1]     = a1;
            num_d[2]     = a2;
            num_d[3]     = b1;
            num_d[4]     = b2;
            div_d        = b0;
            rem_d        = '0;
            quo_d        = {in_abs, {Q_WIDTH{1'b0}}};
            bit_cnt_d    = '0;
            coef_idx_d   = '0;
            coef_state_d = CoefDiv;
          end
        end
      end
      CoefDiv: begin
        if (trial >= {1'b0, div_q}) begin
          rem_d = DATA_WIDTH'(trial - {1'b0, div_q});
          quo_d = {quo_q[DivW-2:0], 1'b1};
        end else begin
          rem_d = trial[DATA_WIDTH-1:0];
          quo_d = {quo_q[DivW-2:0], 1'b0};
        end
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CntW'(DivW - 1)) coef_state_d = CoefFin;
      end
      CoefFin: begin
        shadow_d[coef_idx_q] = div_res;
        if (coef_idx_q == LastIdx) begin
          coef_state_d = CoefWait;
        end else begin
          for (int i = 0; i < NumCoef - 1; i++) num_d[i] = num_q[i+1];
          coef_idx_d   = coef_idx_q + 1'b1;
          rem_d        = '0;
          quo_d        = {next_abs, {Q_WIDTH{1'b0}}};
          bit_cnt_d    = '0;
          coef_state_d = CoefDiv;
        end
      end
      CoefWait: begin
        if (smp_state_q == SmpIdle) begin
          act_d        = shadow_q;
          coef_state_d = CoefIdle;
        end
      end
    endcase
  end

  // Sample path: five MAC cycles, round/saturate, then hold the result until taken.
  always_comb begin
    smp_state_d  = smp_state_q;
    mac_cnt_d    = mac_cnt_q;
    acc_d        = acc_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    out_sample_d = out_sample_q;

    case (mac_cnt_q)
      3'd0: begin mac_coef = act_q[0]; mac_x = x0_q; end
      3'd1: begin mac_coef = act_q[1]; mac_x = x1_q; end
      3'd2: begin mac_coef = act_q[2]; mac_x = x2_q; end
      3'd3: begin mac_coef = act_q[3]; mac_x = y1_q; end
      default: begin mac_coef = act_q[4]; mac_x = y2_q; end
    endcase

    coef_ext = ProdW'(mac_coef);
    x_ext    = ProdW'(mac_x);
    prod     = coef_ext * x_ext;
    prod_ext = ACC_WIDTH'(prod);

    acc_rnd = acc_q + RoundHalf;
    y_full  = acc_rnd >>> Q_WIDTH;
    if (y_full > SmpMax)      y_sat = SmpMax[SAMPLE_WIDTH-1:0];
    else if (y_full < SmpMin) y_sat = SmpMin[SAMPLE_WIDTH-1:0];
    else                      y_sat = y_full[SAMPLE_WIDTH-1:0];

    unique case (smp_state_q)
      SmpIdle: begin
        if (in_valid && !commit_pending) begin
          x0_d        = in_sample;
          acc_d       = '0;
          mac_cnt_d   = '0;
          smp_state_d = SmpMac;
        end
      end
      SmpMac: begin
        // Taps 3 and 4 are the feedback terms and are subtracted.
        if (mac_cnt_q >= 3'd3) acc_d = acc_q - prod_ext;
        else                   acc_d = acc_q + prod_ext;
        mac_cnt_d = mac_cnt_q + 1'b1;
        if (mac_cnt_q == LastIdx) smp_state_d = SmpRound;
      end
      SmpRound: begin
        x2_d         = x1_q;
        x1_d         = x0_q;
        y2_d         = y1_q;
        y1_d         = y_sat;
        out_sample_d = y_sat;
        smp_state_d  = SmpOut;
      end
      SmpOut: begin
        if (out_ready) smp_state_d = SmpIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_state_q <= CoefIdle;
      smp_state_q  <= SmpIdle;
      coef_error_q <= 1'b0;
      for (int i = 0; i < NumCoef; i++) begin
        num_q[i]    <= '0;
        shadow_q[i] <= '0;
        act_q[i]    <= '0;
      end
      act_q[0]     <= CoefOne;
      div_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      bit_cnt_q    <= '0;
      coef_idx_q   <= '0;
      mac_cnt_q    <= '0;
      acc_q        <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      out_sample_q <= '0;
    end else begin
      coef_state_q <= coef_state_d;
      smp_state_q  <= smp_state_d;
      coef_error_q <= coef_error_d;
      num_q        <= num_d;
      shadow_q     <= shadow_d;
      act_q        <= act_d;
      div_q        <= div_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      bit_cnt_q    <= bit_cnt_d;
      coef_idx_q   <= coef_idx_d;
      mac_cnt_q    <= mac_cnt_d;
      acc_q        <= acc_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign coef_ready = (coef_state_q == CoefIdle);
  assign coef_error = coef_error_q;
  assign in_ready   = (smp_state_q == SmpIdle) && !commit_pending;
  assign out_valid  = (smp_state_q == SmpOut);
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_biquad_filter_engine.sv
// Directed bench for biquad_filter_engine: timing, normalization, feedback, saturation,
// commit ordering against in-flight samples, backpressure and reset recovery.
module tb_biquad_filter_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_valid, coef_ready, coef_error;
  logic [31:0] a0, a1, a2, b0, b1, b2;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_sample, out_sample;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  biquad_filter_engine dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .coef_error (coef_error),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  // Offer one sample at the current cycle, expect the result 7 cycles later.
  task automatic run_sample(input logic [23:0] x, input logic [23:0] exp_y, input string name);
    int lat;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: in_ready=%b expected 1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_sample = x;
    step;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
    n_checks++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles expected 7", name, lat);
    end
    n_checks++;
    if (out_sample !== exp_y) begin
      n_fail++;
      $display("FAIL %s_value: out_sample=%0d expected %0d", name, $signed(out_sample),
               $signed(exp_y));
    end
    step;
  endtask

  task automatic load_coef(input logic [31:0] c_a0, input logic [31:0] c_a1,
                           input logic [31:0] c_a2, input logic [31:0] c_b0,
                           input logic [31:0] c_b1, input logic [31:0] c_b2,
                           input bit exp_err, input string name);
    int   lat;
    logic ir_commit;
    n_checks++;
    if (coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_before: coef_ready=%b expected 1", name, coef_ready);
    end
    a0 = c_a0; a1 = c_a1; a2 = c_a2; b0 = c_b0; b1 = c_b1; b2 = c_b2;
    coef_valid = 1'b1;
    step;
    coef_valid = 1'b0;
    if (exp_err) begin
      n_checks++;
      if (coef_error !== 1'b1 || coef_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_error: coef_error=%b coef_ready=%b expected 1 1", name, coef_error,
                 coef_ready);
      end
    end else begin
      n_checks++;
      if (coef_error !== 1'b0 || coef_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_start: coef_error=%b coef_ready=%b expected 0 0", name, coef_error,
                 coef_ready);
      end
      lat = 1;
      ir_commit = 1'bx;
      while (coef_ready !== 1'b1 && lat < 400) begin
        if (lat == 286) ir_commit = in_ready;
        step;
        lat++;
      end
      n_checks++;
      if (lat !== 287) begin
        n_fail++;
        $display("FAIL %s_latency: coef_ready after %0d cycles expected 287", name, lat);
      end
      n_checks++;
      if (ir_commit !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_commit_in_ready: in_ready=%b on commit cycle expected 0", name,
                 ir_commit);
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (coef_ready !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_sample !== 24'd0 || coef_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: coef_ready=%b in_ready=%b out_valid=%b out_sample=%0d err=%b expected 1 1 0 0 0",
               coef_ready, in_ready, out_valid, out_sample, coef_error);
    end
  endtask

  task automatic test_passthrough;
    run_sample(24'd1000, 24'd1000, "pass_pos");
    run_sample(-24'sd1001, -24'sd1001, "pass_neg");
  endtask

  task automatic test_half_gain;
    load_coef(32'h0080_0000, 32'h0, 32'h0, 32'h0100_0000, 32'h0, 32'h0, 1'b0, "half_load");
    run_sample(24'd1000, 24'd500, "half_pos");
    run_sample(-24'sd1001, -24'sd500, "half_neg");
  endtask

  task automatic test_normalize;
    load_coef(32'h0200_0000, 32'h0, 32'h0, 32'h0200_0000, 32'h0, 32'h0, 1'b0, "norm_load");
    run_sample(24'd1234, 24'd1234, "norm_unity");
    load_coef(32'h0040_0000, 32'h0, 32'h0, 32'hFF00_0000, 32'h0, 32'h0, 1'b1, "norm_negb0");
    run_sample(24'd777, 24'd777, "norm_kept");
    load_coef(32'h0040_0000, 32'h0, 32'h0, 32'h0000_0000, 32'h0, 32'h0, 1'b1, "norm_zerob0");
  endtask

  task automatic test_feedback;
    do_reset;
    load_coef(32'h0100_0000, 32'h0, 32'h0, 32'h0100_0000, 32'hFF80_0000, 32'h0, 1'b0, "fb_load");
    run_sample(24'd1000, 24'd1000, "fb_y0");
    run_sample(24'd0, 24'd500, "fb_y1");
    run_sample(24'd0, 24'd250, "fb_y2");
    run_sample(24'd0, 24'd125, "fb_y3");
  endtask

  task automatic test_saturation;
    load_coef(32'h7F00_0000, 32'h0, 32'h0, 32'h0100_0000, 32'h0, 32'h0, 1'b0, "sat_load");
    run_sample(24'h7F_FFFF, 24'h7F_FFFF, "sat_pos");
    run_sample(24'h80_0000, 24'h80_0000, "sat_neg");
    load_coef(32'h7F00_0000, 32'h0, 32'h0, 32'h0000_0001, 32'h0, 32'h0, 1'b0, "divsat_pos");
    run_sample(24'd1, 24'd128, "divsat_pos_out");
    load_coef(32'h8000_0000, 32'h0, 32'h0, 32'h0000_0001, 32'h0, 32'h0, 1'b0, "divsat_neg");
    run_sample(24'd1, -24'sd128, "divsat_neg_out");
  endtask

  task automatic test_concurrency;
    int lat;
    load_coef(32'h0100_0000, 32'h0, 32'h0, 32'h0100_0000, 32'h0, 32'h0, 1'b0, "conc_unity");
    a0 = 32'h0080_0000; a1 = 32'h0; a2 = 32'h0; b0 = 32'h0100_0000; b1 = 32'h0; b2 = 32'h0;
    coef_valid = 1'b1;
    step;
    coef_valid = 1'b0;
    repeat (282) step;
    // Sample accepted at T+283 is still in MAC when the new bank becomes pending.
    in_valid  = 1'b1;
    in_sample = 24'd1000;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_accept: in_ready=%b expected 1", in_ready);
    end
    step;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
    n_checks++;
    if (lat !== 6 || out_sample !== 24'd1000) begin
      n_fail++;
      $display("FAIL conc_old_bank: lat=%0d out_sample=%0d expected 6 1000", lat,
               $signed(out_sample));
    end
    step;
    in_valid  = 1'b1;
    in_sample = 24'd1000;
    n_checks++;
    if (in_ready !== 1'b0 || coef_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL conc_commit_cycle: in_ready=%b coef_ready=%b expected 0 0", in_ready,
               coef_ready);
    end
    step;
    n_checks++;
    if (in_ready !== 1'b1 || coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_after_commit: in_ready=%b coef_ready=%b expected 1 1", in_ready,
               coef_ready);
    end
    step;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
    n_checks++;
    if (lat !== 6 || out_sample !== 24'd500) begin
      n_fail++;
      $display("FAIL conc_new_bank: lat=%0d out_sample=%0d expected 6 500", lat,
               $signed(out_sample));
    end
    step;
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: in_ready=%b expected 1", in_ready);
    end
    in_valid  = 1'b1;
    in_sample = 24'd2000;
    step;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
    n_checks++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d expected 7", lat);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_sample !== 24'd1000 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_sample=%0d in_ready=%b expected 1 1000 0",
                 i, out_valid, $signed(out_sample), in_ready);
      end
      step;
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b expected 1", out_valid);
    end
    step;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op;
    logic seen_out;
    // Reset in the middle of MAC abandons the sample.
    in_valid  = 1'b1;
    in_sample = 24'd3000;
    step;
    in_valid = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sample !== 24'd0) begin
      n_fail++;
      $display("FAIL rst_mac: out_valid=%b in_ready=%b out_sample=%0d expected 0 1 0",
               out_valid, in_ready, $signed(out_sample));
    end
    seen_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen_out = 1'b1;
      step;
    end
    n_checks++;
    if (seen_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mac_stray: out_valid seen=%b expected 0", seen_out);
    end
    // Bank is passthrough again; reset mid-division must keep it that way.
    load_coef(32'h0080_0000, 32'h0, 32'h0, 32'h0100_0000, 32'h0, 32'h0, 1'b1 ^ 1'b1, "rst_pre");
    a0 = 32'h0040_0000; b0 = 32'h0100_0000; a1 = 32'h0; a2 = 32'h0; b1 = 32'h0; b2 = 32'h0;
    coef_valid = 1'b1;
    step;
    coef_valid = 1'b0;
    repeat (100) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_checks++;
    if (coef_ready !== 1'b1 || in_ready !== 1'b1 || coef_error !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_div: coef_ready=%b in_ready=%b coef_error=%b expected 1 1 0",
               coef_ready, in_ready, coef_error);
    end
    run_sample(24'd1000, 24'd1000, "rst_div_pass");
    repeat (300) step;
    n_checks++;
    if (coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_div_late: coef_ready=%b expected 1", coef_ready);
    end
    run_sample(-24'sd1001, -24'sd1001, "rst_div_late_pass");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    coef_valid = 1'b0;
    a0 = 32'h0; a1 = 32'h0; a2 = 32'h0; b0 = 32'h0; b1 = 32'h0; b2 = 32'h0;
    in_valid   = 1'b0;
    in_sample  = 24'd0;
    out_ready  = 1'b1;
    repeat (3) step;
    rst = 1'b0;

    test_reset;
    test_passthrough;
    test_half_gain;
    test_normalize;
    test_feedback;
    test_saturation;
    test_concurrency;
    test_backpressure;
    test_reset_mid_op;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_filter_engine.md
# biquad_filter_engine

Sequential Direct Form I biquad that consumes the unnormalized Q8.24 coefficient set produced by the coefficient calculator and applies it to the audio sample stream. It normalizes each new set by b0 with a serial divider, holds the result in a shadow bank, and commits it at a sample boundary. Filtering is time-multiplexed over a single multiply-accumulate unit. It sits between the coefficient calculator and the pedal's audio output path.

## Interface
- DATA_WIDTH, 32, coefficient width (signed Q8.24)
- Q_WIDTH, 24, coefficient fractional bits
- SAMPLE_WIDTH, 24, signed integer audio sample width
- ACC_WIDTH, 60, signed accumulator width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- coef_valid  in  1  coefficient set offered
- coef_ready  out  1  engine accepts a coefficient set
- a0, a1, a2  in  DATA_WIDTH  signed feedforward (numerator) coefficients
- b0, b1, b2  in  DATA_WIDTH  signed feedback (denominator) coefficients; b0 is the normalizer
- coef_error  out  1  sticky flag: last offered set had b0 <= 0
- in_valid, in_ready, in_sample  in/out/in  1/1/SAMPLE_WIDTH  input sample handshake
- out_valid, out_ready, out_sample  out/in/out  1/1/SAMPLE_WIDTH  output sample handshake

## Operation
- Reset values:
  - coef_ready=1, in_ready=1, out_valid=0, out_sample=0, coef_error=0.
  - Active bank is passthrough: n_a0=0x01000000; n_a1, n_a2, n_b1, n_b2 = 0.
  - History x1, x2, y1, y2 = 0; shadow bank empty, no commit pending.
- Coefficient load (coef_valid && coef_ready, cycle T):
  - Capture all six inputs. coef_ready drops at T+1.
  - If b0 <= 0: set coef_error=1, discard the set, coef_ready=1 at T+1. The active bank is unchanged.
  - Otherwise clear coef_error and compute n_a0 = a0/b0, then n_a1, n_a2, n_b1, n_b2 in that order.
- Divider (signed restoring):
  - Dividend |x|<<Q_WIDTH (56 bits), divisor b0.
  - DATA_WIDTH+Q_WIDTH = 56 iteration cycles, plus 1 finalize cycle that applies the sign, saturates to signed 32 bits (0x7FFFFFFF / 0x80000000), and writes the shadow register.
  - Truncates toward zero. 57 cycles per coefficient, 285 total.
- Commit:
  - Shadow bank is pending from T+286.
  - Commit copies shadow to active on the first cycle the sample FSM is in IDLE with a commit pending. That cycle has priority over sample acceptance (in_ready=0).
  - History is not cleared on commit.
  - coef_ready=1 the cycle after commit.
- Sample FSM states: IDLE -> MAC -> ROUND -> OUT -> IDLE.
  - IDLE: in_ready=1 unless a commit is pending. On in_valid && in_ready, latch x0 and go to MAC.
  - MAC: 5 cycles, one product per cycle, in the order n_a0*x0, n_a1*x1, n_a2*x2, -n_b1*y1, -n_b2*y2. Each product is 56-bit signed with Q_WIDTH fractional bits, sign-extended into ACC_WIDTH. The accumulator clears on entry.
  - ROUND:
    - y = (acc + 2^(Q_WIDTH-1)) >>> Q_WIDTH, i.e. round half up.
    - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
    - Update x2<=x1, x1<=x0, y2<=y1, y1<=y (saturated value).
  - OUT: out_valid=1, out_sample=y held stable until out_ready. Go to IDLE on the cycle out_valid && out_ready.
- Coefficient loading and sample processing run concurrently; only the commit touches the active bank.

## Timing
- Sample latency: accept at cycle T (IDLE), MAC T+1..T+5, ROUND T+6, out_valid from T+7.
- With out_ready held high, the next sample is accepted at T+8; throughput is 1 sample per 8 cycles.
- Backpressure: the FSM stays in OUT and in_ready=0 while out_ready=0.
- Coefficient latency with the engine idle: accept at T, commit at T+286, coef_ready=1 at T+287.
- If a sample is in flight at T+286, the commit waits for the return to IDLE. The sample in flight finishes with the old bank.
- coef_valid while coef_ready=0 is ignored; the source holds it until accepted.
- in_valid and a pending commit in the same IDLE cycle: commit wins, and the sample is accepted next cycle.
- rst at any cycle, including mid-division or mid-MAC, abandons the operation and restores every reset value on the next edge, passthrough bank included.

## Test plan
- Passthrough after reset: in_sample 1000, then -1001 -> out_sample 1000 at T+7, then -1001.
- Load a0=0x00800000, b0=0x01000000, others 0 -> coef_ready back at T+287. Inputs 1000 and -1001 -> outputs 500 and -500.
- Normalization: a0=0x02000000, b0=0x02000000, others 0 -> input 1234 gives output 1234. Negative b0 (0xFF000000) -> coef_error=1, coef_ready=1 next cycle, passthrough kept.
- Feedback: a0=0x01000000, b0=0x01000000, b1=0xFF800000 (-0.5); impulse 1000, 0, 0 -> outputs 1000, 500, 250.
- Saturation: a0=0x7F000000 -> inputs 8388607 and -8388608 give 8388607 and -8388608.
- Concurrency and backpressure:
  - Coefficient load issued mid-sample -> the in-flight sample uses the old bank; in_ready=0 on the commit cycle.
  - out_ready held low 10 cycles -> out_sample stable and in_ready=0 throughout.
  - rst mid-division -> passthrough restored, coef_ready=1.
